// File: rtl/symbol_packer.sv
// Packs SYM_W-bit symbols LSB-first into WORD_W-bit words behind a one-entry output register.
// Optional partial-word flush is enabled by defining SYMBOL_PACKER_FLUSH_EN.
module symbol_packer #(
  parameter int SYM_W  = 2,
  parameter int WORD_W = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SYM_W-1:0]                 sym_in,
  input  logic                             sym_valid_in,
  output logic                             sym_ready_out,
  input  logic                             flush_in,
  output logic [WORD_W-1:0]                data_out,
  output logic                             valid_data_out,
  input  logic                             data_ready_in,
  output logic [$clog2(WORD_W/SYM_W):0]    data_len_out,
  output logic [$clog2(WORD_W/SYM_W)-1:0]  sym_cnt_out
);

  localparam int N  = WORD_W / SYM_W;
  localparam int CW = $clog2(N);
  localparam int LW = CW + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_LAST
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] acc;
  logic [CW-1:0]     sym_cnt;
  logic              flush_pending;

  logic [WORD_W-1:0] acc_next;
  logic [LW-1:0]     cnt_with;
  logic              accept;
  logic              out_free;
  logic              full;
  logic              flush_req;
  logic              fire;

  function automatic state_t state_of(input logic [CW-1:0] c);
    if (c == '0)
      return S_EMPTY;
    else if (c == CW'(N - 1))
      return S_LAST;
    else
      return S_FILL;
  endfunction

  // A pending flush blocks input so the partial word it captures cannot grow.
  assign sym_ready_out = !flush_pending &&
                         !(state == S_LAST && valid_data_out && !data_ready_in);
  assign accept   = sym_valid_in && sym_ready_out;
  assign out_free = !valid_data_out || data_ready_in;
  assign full     = accept && (state == S_LAST);

  always_comb begin
    acc_next = acc;
    for (int k = 0; k < N; k++) begin
      if (accept && sym_cnt == CW'(k))
        acc_next[k*SYM_W +: SYM_W] = sym_in;
    end
    cnt_with = {1'b0, sym_cnt} + LW'(accept);
  end

`ifdef SYMBOL_PACKER_FLUSH_EN
  assign flush_req = (flush_in || flush_pending) && (cnt_with != '0);
`else
  logic unused_flush;
  assign unused_flush = flush_in;
  assign flush_req    = 1'b0;
`endif

  // Accepting the last slot only happens when the output is free, so full always fires.
  assign fire = full || (flush_req && out_free);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_EMPTY;
      acc            <= '0;
      sym_cnt        <= '0;
      flush_pending  <= 1'b0;
      data_out       <= '0;
      valid_data_out <= 1'b0;
      data_len_out   <= '0;
    end else if (fire) begin
      data_out       <= acc_next;
      data_len_out   <= cnt_with;
      valid_data_out <= 1'b1;
      acc            <= '0;
      sym_cnt        <= '0;
      state          <= S_EMPTY;
      flush_pending  <= 1'b0;
    end else begin
      if (data_ready_in)
        valid_data_out <= 1'b0;
      acc           <= acc_next;
      sym_cnt       <= cnt_with[CW-1:0];
      state         <= state_of(cnt_with[CW-1:0]);
      flush_pending <= flush_req;
    end
  end

  assign sym_cnt_out = sym_cnt;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed self-checking bench for symbol_packer (default 2-bit symbols, 32-bit words).
module tb_symbol_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sym_in = '0;
  logic        sym_valid_in = 1'b0;
  logic        sym_ready_out;
  logic        flush_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_data_out;
  logic        data_ready_in = 1'b0;
  logic [4:0]  data_len_out;
  logic [3:0]  sym_cnt_out;

  int checks = 0;
  int errors = 0;

  symbol_packer #(.SYM_W(2), .WORD_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .sym_in         (sym_in),
    .sym_valid_in   (sym_valid_in),
    .sym_ready_out  (sym_ready_out),
    .flush_in       (flush_in),
    .data_out       (data_out),
    .valid_data_out (valid_data_out),
    .data_ready_in  (data_ready_in),
    .data_len_out   (data_len_out),
    .sym_cnt_out    (sym_cnt_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sym_valid_in = 1'b0;
    flush_in = 1'b0;
    data_ready_in = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (data_out !== 32'h0 || valid_data_out !== 1'b0 || data_len_out !== 5'd0 || sym_cnt_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h valid=%b len=%0d cnt=%0d, required 0/0/0/0",
               data_out, valid_data_out, data_len_out, sym_cnt_out);
    end
    checks++;
    if (sym_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", sym_ready_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_pattern();
    data_ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sym_in = 2'(i % 4);
      sym_valid_in = 1'b1;
      step();
      if (i == 14) begin
        checks++;
        if (sym_cnt_out !== 4'd15 || valid_data_out !== 1'b0) begin
          errors++;
          $display("FAIL pattern_last_slot: cnt=%0d valid=%b, required 15/0", sym_cnt_out, valid_data_out);
        end
      end
    end
    sym_valid_in = 1'b0;
    checks++;
    if (data_out !== 32'hE4E4E4E4 || valid_data_out !== 1'b1 || data_len_out !== 5'd16 || sym_cnt_out !== 4'd0) begin
      errors++;
      $display("FAIL pattern_word: data=%h valid=%b len=%0d cnt=%0d, required E4E4E4E4/1/16/0",
               data_out, valid_data_out, data_len_out, sym_cnt_out);
    end
    step();
    checks++;
    if (valid_data_out !== 1'b0) begin
      errors++;
      $display("FAIL pattern_drain: valid=%b, required 0", valid_data_out);
    end
  endtask

  task automatic test_back_to_back();
    int ready_low = 0;
    int bad_valid = 0;
    data_ready_in = 1'b1;
    sym_in = 2'd3;
    sym_valid_in = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (sym_ready_out !== 1'b1) ready_low++;
      step();
      if (valid_data_out !== ((i == 16) || (i == 32))) bad_valid++;
      if (i == 16 || i == 32) begin
        checks++;
        if (data_out !== 32'hFFFFFFFF || data_len_out !== 5'd16) begin
          errors++;
          $display("FAIL b2b_word%0d: data=%h len=%0d, required FFFFFFFF/16", i / 16, data_out, data_len_out);
        end
      end
    end
    sym_valid_in = 1'b0;
    checks++;
    if (ready_low != 0) begin
      errors++;
      $display("FAIL b2b_ready: ready low on %0d cycles, required 0", ready_low);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++;
      $display("FAIL b2b_valid_timing: %0d cycles with wrong valid, required 0", bad_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    data_ready_in = 1'b0;
    sym_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sym_in = 2'(i % 4);
      step();
    end
    checks++;
    if (data_out !== 32'hE4E4E4E4 || valid_data_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_held: data=%h valid=%b, required E4E4E4E4/1", data_out, valid_data_out);
    end
    sym_in = 2'd1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (sym_cnt_out !== 4'd15) begin
      errors++;
      $display("FAIL bp_count: cnt=%0d, required 15", sym_cnt_out);
    end
    #1;
    checks++;
    if (sym_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: ready=%b, required 0", sym_ready_out);
    end
    step();
    checks++;
    if (sym_cnt_out !== 4'd15 || data_out !== 32'hE4E4E4E4 || valid_data_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: cnt=%0d data=%h valid=%b, required 15/E4E4E4E4/1",
               sym_cnt_out, data_out, valid_data_out);
    end
    data_ready_in = 1'b1;
    #1;
    checks++;
    if (sym_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_release: ready=%b, required 1", sym_ready_out);
    end
    step();
    sym_valid_in = 1'b0;
    checks++;
    if (data_out !== 32'h55555555 || valid_data_out !== 1'b1 || data_len_out !== 5'd16 || sym_cnt_out !== 4'd0) begin
      errors++;
      $display("FAIL bp_second_word: data=%h valid=%b len=%0d cnt=%0d, required 55555555/1/16/0",
               data_out, valid_data_out, data_len_out, sym_cnt_out);
    end
    step();
  endtask

  task automatic test_async_reset();
    data_ready_in = 1'b1;
    sym_in = 2'd2;
    sym_valid_in = 1'b1;
    for (int i = 0; i < 7; i++) step();
    sym_valid_in = 1'b0;
    checks++;
    if (sym_cnt_out !== 4'd7) begin
      errors++;
      $display("FAIL arst_pre_count: cnt=%0d, required 7", sym_cnt_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sym_cnt_out !== 4'd0 || data_out !== 32'h0 || valid_data_out !== 1'b0 || data_len_out !== 5'd0) begin
      errors++;
      $display("FAIL arst_immediate: cnt=%0d data=%h valid=%b len=%0d, required 0/0/0/0",
               sym_cnt_out, data_out, valid_data_out, data_len_out);
    end
    step();
    rst = 1'b0;
    step();
    sym_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sym_in = 2'(3 - (i % 4));
      step();
    end
    sym_valid_in = 1'b0;
    checks++;
    if (data_out !== 32'h1B1B1B1B || valid_data_out !== 1'b1 || data_len_out !== 5'd16) begin
      errors++;
      $display("FAIL arst_clean_word: data=%h valid=%b len=%0d, required 1B1B1B1B/1/16",
               data_out, valid_data_out, data_len_out);
    end
    step();
  endtask

`ifdef SYMBOL_PACKER_FLUSH_EN
  task automatic test_flush();
    do_reset();
    data_ready_in = 1'b0;
    sym_valid_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sym_in = 2'(i);
      step();
    end
    sym_valid_in = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    checks++;
    if (data_out !== 32'h00000039 || data_len_out !== 5'd3 || valid_data_out !== 1'b1 || sym_cnt_out !== 4'd0) begin
      errors++;
      $display("FAIL flush_partial: data=%h len=%0d valid=%b cnt=%0d, required 00000039/3/1/0",
               data_out, data_len_out, valid_data_out, sym_cnt_out);
    end
    sym_in = 2'd2;
    sym_valid_in = 1'b1;
    step();
    step();
    sym_valid_in = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    checks++;
    if (sym_ready_out !== 1'b0 || data_out !== 32'h00000039 || sym_cnt_out !== 4'd2) begin
      errors++;
      $display("FAIL flush_pending: ready=%b data=%h cnt=%0d, required 0/00000039/2",
               sym_ready_out, data_out, sym_cnt_out);
    end
    step();
    checks++;
    if (sym_ready_out !== 1'b0 || valid_data_out !== 1'b1 || data_out !== 32'h00000039) begin
      errors++;
      $display("FAIL flush_still_pending: ready=%b valid=%b data=%h, required 0/1/00000039",
               sym_ready_out, valid_data_out, data_out);
    end
    data_ready_in = 1'b1;
    step();
    checks++;
    if (data_out !== 32'h0000000A || data_len_out !== 5'd2 || valid_data_out !== 1'b1 || sym_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_deferred: data=%h len=%0d valid=%b ready=%b, required 0000000A/2/1/1",
               data_out, data_len_out, valid_data_out, sym_ready_out);
    end
    sym_in = 2'd3;
    sym_valid_in = 1'b1;
    flush_in = 1'b1;
    step();
    sym_valid_in = 1'b0;
    flush_in = 1'b0;
    checks++;
    if (data_out !== 32'h00000003 || data_len_out !== 5'd1 || sym_cnt_out !== 4'd0) begin
      errors++;
      $display("FAIL flush_same_cycle: data=%h len=%0d cnt=%0d, required 00000003/1/0",
               data_out, data_len_out, sym_cnt_out);
    end
    step();
  endtask
`else
  task automatic test_flush_ignored();
    do_reset();
    data_ready_in = 1'b1;
    sym_valid_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sym_in = 2'(i);
      flush_in = (i == 3);
      step();
    end
    sym_valid_in = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    step();
    checks++;
    if (valid_data_out !== 1'b0 || sym_cnt_out !== 4'd3) begin
      errors++;
      $display("FAIL flush_ignored: valid=%b cnt=%0d, required 0/3", valid_data_out, sym_cnt_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pattern();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
`ifdef SYMBOL_PACKER_FLUSH_EN
    test_flush();
`else
    test_flush_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
